// File: rtl/uart_tx_engine.sv
// UART serial transmit engine: pops bytes from the TX FIFO and
// frames them as start / data / optional even parity / stop bits.
module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 bus2ip_clk,
    input  logic                 bus2ip_rst,
    input  logic [15:0]          baud_config_i,
    input  logic                 parity_en_i,
    input  logic                 msb_first_i,
    input  logic                 start_polarity_i,
    input  logic                 reset_buffer_i,
    input  logic                 tx_buffer_data_present_i,
    input  logic [DATA_BITS-1:0] tx_buffer_data_i,
    output logic                 tx_buffer_rd_o,
    output logic                 uart_tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [15:0]          div_q;
    logic [15:0]          presc;
    logic [15:0]          presc_n;
    logic [TW-1:0]        tick;
    logic [TW-1:0]        tick_n;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;
    logic                 msb_q;
    logic                 pol_q;
    logic                 tx_q;
    logic                 tick_wrap;
    logic                 bit_end;
    logic                 pre_end;
    logic                 pop;

    function automatic logic pick(
        input logic [DATA_BITS-1:0] d,
        input logic                 msb,
        input logic [IW-1:0]        i
    );
        return msb ? d[IDX_LAST - i] : d[i];
    endfunction

    // pre_end flags the cycle before the last one of a bit period
    always_comb begin
        tick_wrap = (presc == div_q - 16'd1);
        bit_end   = tick_wrap && (tick == TICK_LAST);
        presc_n   = tick_wrap ? 16'd0 : presc + 16'd1;
        tick_n    = tick;
        if (tick_wrap)
            tick_n = (tick == TICK_LAST) ? '0 : tick + 1'b1;
        pre_end   = (presc_n == div_q - 16'd1) && (tick_n == TICK_LAST);
    end

    assign pop = (state == IDLE) && tx_buffer_data_present_i &&
                 !reset_buffer_i && !bus2ip_rst;

    assign tx_buffer_rd_o = pop;
    assign tx_busy_o      = (state != IDLE) || pop;
    assign uart_tx_o      = bus2ip_rst ? ~start_polarity_i : tx_q;

    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            state     <= IDLE;
            div_q     <= 16'd1;
            presc     <= '0;
            tick      <= '0;
            idx       <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            msb_q     <= 1'b0;
            pol_q     <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_o <= 1'b0;
        end else begin
            tx_done_o <= 1'b0;
            if (reset_buffer_i) begin
                state <= IDLE;
                tx_q  <= ~start_polarity_i;
            end else begin
                if (state != IDLE) begin
                    presc <= presc_n;
                    tick  <= tick_n;
                end
                unique case (state)
                    IDLE: begin
                        tx_q <= ~start_polarity_i;
                        if (pop) begin
                            data_q <= tx_buffer_data_i;
                            div_q  <= (baud_config_i == 16'd0) ?
                                      16'd1 : baud_config_i;
                            par_q  <= parity_en_i;
                            msb_q  <= msb_first_i;
                            pol_q  <= start_polarity_i;
                            presc  <= '0;
                            tick   <= '0;
                            idx    <= '0;
                            tx_q   <= start_polarity_i;
                            state  <= START;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            tx_q  <= pick(data_q, msb_q, '0);
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (idx == IDX_LAST) begin
                                if (par_q) begin
                                    tx_q  <= ^data_q;
                                    state <= PARITY;
                                end else begin
                                    tx_q  <= ~pol_q;
                                    state <= STOP;
                                end
                            end else begin
                                idx  <= idx + 1'b1;
                                tx_q <= pick(data_q, msb_q, idx + 1'b1);
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            tx_q  <= ~pol_q;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (pre_end)
                            tx_done_o <= 1'b1;
                        if (bit_end) begin
                            tx_q  <= ~pol_q;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a monitor captures every frame off the line,
// tests compare captures against constant tables and a frame model.
module tb_uart_tx_engine;

    localparam int DB = 8;
    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud;
    logic        par;
    logic        msb;
    logic        sp;
    logic        rbuf;
    logic        present;
    logic [7:0]  data;
    logic        rd;
    logic        tx;
    logic        busy;
    logic        done;

    always #4 clk = ~clk;

    uart_tx_engine #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .bus2ip_clk              (clk),
        .bus2ip_rst              (rst),
        .baud_config_i           (baud),
        .parity_en_i             (par),
        .msb_first_i             (msb),
        .start_polarity_i        (sp),
        .reset_buffer_i          (rbuf),
        .tx_buffer_data_present_i(present),
        .tx_buffer_data_i        (data),
        .tx_buffer_rd_o          (rd),
        .uart_tx_o               (tx),
        .tx_busy_o               (busy),
        .tx_done_o               (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          rd_cyc;
        int          nbits;
        int          per;
        logic [10:0] lv;
        bit          stable;
        int          done_off;
        bit          busy_ok;
        bit          extra_rd;
        bit          aborted;
        logic        ab_line;
        logic        ab_busy;
        logic        ab_done;
    } cap_t;

    cap_t cap_q[$];
    int   rd_cycles[$];
    int   done_cycles[$];
    int   cyc = 0;
    cap_t cur;
    bit   in_frame = 0;
    bit   ab_pend = 0;
    int   off;
    int   mb;

    // line monitor: sampled on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_frame = 0;
                ab_pend  = 0;
            end else begin
                if (done === 1'b1) done_cycles.push_back(cyc);
                if (rd === 1'b1) rd_cycles.push_back(cyc);
                if (ab_pend) begin
                    cur.ab_line = tx;
                    cur.ab_busy = busy;
                    cur.ab_done = done;
                    cap_q.push_back(cur);
                    ab_pend = 0;
                end
                if (in_frame) begin
                    mb = off / cur.per;
                    if (off % cur.per == 0) cur.lv[mb] = tx;
                    else if (tx !== cur.lv[mb]) cur.stable = 0;
                    if (busy !== 1'b1) cur.busy_ok = 0;
                    if (rd === 1'b1) cur.extra_rd = 1;
                    if (done === 1'b1 && cur.done_off < 0) cur.done_off = off;
                    if (rbuf) begin
                        cur.aborted = 1;
                        ab_pend     = 1;
                        in_frame    = 0;
                    end else begin
                        off++;
                        if (off == cur.nbits * cur.per) begin
                            cap_q.push_back(cur);
                            in_frame = 0;
                        end
                    end
                end else if (rd === 1'b1) begin
                    cur.rd_cyc   = cyc;
                    cur.nbits    = par ? 11 : 10;
                    cur.per      = OS * ((baud == 16'd0) ? 1 : int'(baud));
                    cur.lv       = '0;
                    cur.stable   = 1;
                    cur.done_off = -1;
                    cur.busy_ok  = 1;
                    cur.extra_rd = 0;
                    cur.aborted  = 0;
                    cur.ab_line  = 1'bx;
                    cur.ab_busy  = 1'bx;
                    cur.ab_done  = 1'bx;
                    off          = 0;
                    in_frame     = 1;
                end
            end
        end
    end

    // frame as a bit string, first transmitted bit leftmost
    function automatic logic [10:0] model_frame(input logic [7:0] d,
                                                input bit p, input bit m,
                                                input bit s);
        logic [10:0] f = '0;
        f = {f[9:0], s};
        for (int i = 0; i < 8; i++)
            f = {f[9:0], (m ? d[7-i] : d[i])};
        if (p) f = {f[9:0], ^d};
        f = {f[9:0], ~s};
        return f;
    endfunction

    function automatic logic [10:0] cap_ord(input cap_t c);
        logic [10:0] o = '0;
        for (int b = 0; b < c.nbits; b++)
            o = {o[9:0], c.lv[b]};
        return o;
    endfunction

    task automatic check_frame(input string nm, input cap_t c,
                               input logic [10:0] exp, input int n,
                               input int per);
        check({nm, "_bits"}, cap_ord(c), exp);
        check({nm, "_len"}, c.nbits, n);
        check({nm, "_stable"}, c.stable, 1);
        check({nm, "_done"}, c.done_off, n * per - 1);
        check({nm, "_busy"}, c.busy_ok, 1);
        check({nm, "_rd"}, c.extra_rd, 0);
    endtask

    task automatic wait_caps(input int target, input int limit);
        int k = 0;
        while (cap_q.size() < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("frame_timeout", cap_q.size() >= target, 1);
    endtask

    // present one byte, wait for its pop, then scramble the config inputs
    task automatic pop_one(input logic [7:0] d, input logic [15:0] b,
                           input bit p, input bit m, input bit s);
        int k = 0;
        @(posedge clk); #2;
        data = d; baud = b; par = p; msb = m; sp = s; present = 1'b1;
        @(negedge clk);
        while (rd !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("pop_seen", rd, 1);
        @(posedge clk); #2;
        present = 1'b0;
        baud    = 16'($urandom_range(0, 5));
        par     = 1'($urandom);
        msb     = 1'($urandom);
        sp      = 1'($urandom);
        data    = 8'($urandom);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] b;
        bit          p;
        bit          m;
        bit          s;
        int          n;
        int          per;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rb;
        int db;
        int k;
        int ndone;

        vecs[0] = '{8'h31, 16'd2, 0, 0, 0, 10, 32, 11'b0_0100011001};
        vecs[1] = '{8'h31, 16'd2, 1, 1, 0, 11, 32, 11'b00011000111};
        vecs[2] = '{8'h31, 16'd0, 0, 0, 1, 10, 16, 11'b0_1100011000};
        vecs[3] = '{8'hA5, 16'd1, 1, 0, 0, 11, 16, 11'b01010010101};
        vecs[4] = '{8'h00, 16'd3, 1, 1, 1, 11, 48, 11'b10000000000};
        vecs[5] = '{8'hFF, 16'd1, 0, 1, 0, 10, 16, 11'b0_0111111111};

        rst = 1'b1; baud = 16'd2; par = 0; msb = 0; sp = 0;
        rbuf = 0; present = 0; data = '0;
        repeat (3) @(negedge clk);
        check("rst_line", tx, 1);
        check("rst_rd", rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        sp = 1'b1;
        #1 check("rst_line_pol", tx, 0);
        sp = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        sp = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_pol1", tx, 0);
        @(posedge clk); #2;
        sp = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_pol0", tx, 1);

        for (int i = 0; i < 6; i++) begin
            check($sformatf("v%0d_idle_busy", i), busy, 0);
            base = cap_q.size();
            pop_one(vecs[i].d, vecs[i].b, vecs[i].p, vecs[i].m, vecs[i].s);
            wait_caps(base + 1, 1000);
            if (cap_q.size() > base)
                check_frame($sformatf("v%0d", i), cap_q[base], vecs[i].exp,
                            vecs[i].n, vecs[i].per);
            repeat (3) @(posedge clk);
        end

        // two queued bytes, baud changed while the first frame runs
        @(posedge clk); #2;
        sp = 0; par = 0; msb = 0;
        base = cap_q.size();
        rb   = rd_cycles.size();
        db   = done_cycles.size();
        data = 8'h31; baud = 16'd2; present = 1'b1;
        k = 0;
        @(negedge clk);
        while (rd !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("b2b_pop1", rd, 1);
        @(posedge clk); #2;
        data = 8'h5A; baud = 16'd1;
        k = 0;
        @(negedge clk);
        while (rd !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        check("b2b_pop2", rd, 1);
        @(posedge clk); #2;
        present = 1'b0;
        wait_caps(base + 2, 1000);
        if (cap_q.size() >= base + 2 && rd_cycles.size() >= rb + 2 &&
            done_cycles.size() > db) begin
            check_frame("b2b_f1", cap_q[base], model_frame(8'h31, 0, 0, 0),
                        10, 32);
            check_frame("b2b_f2", cap_q[base+1], model_frame(8'h5A, 0, 0, 0),
                        10, 16);
            check("b2b_rd_after_done", rd_cycles[rb+1] - done_cycles[db], 1);
            check("b2b_pop_spacing", rd_cycles[rb+1] - rd_cycles[rb], 321);
        end else begin
            check("b2b_capture", 0, 1);
        end
        repeat (3) @(posedge clk);

        // flush during data bit 3, then a clean frame
        ndone = done_cycles.size();
        base  = cap_q.size();
        pop_one(8'h31, 16'd1, 0, 0, 0);
        repeat (66) @(posedge clk);
        #2;
        rbuf = 1'b1; sp = 1'b0;
        @(posedge clk); #2;
        rbuf = 1'b0;
        wait_caps(base + 1, 100);
        if (cap_q.size() > base) begin
            check("abort_flag", cap_q[base].aborted, 1);
            check("abort_line", cap_q[base].ab_line, 1);
            check("abort_busy", cap_q[base].ab_busy, 0);
            check("abort_done", cap_q[base].ab_done, 0);
            check("abort_no_done", cap_q[base].done_off, -1);
        end
        check("abort_done_count", done_cycles.size(), ndone);
        repeat (4) @(posedge clk);
        base = cap_q.size();
        pop_one(8'h31, 16'd1, 0, 0, 0);
        wait_caps(base + 1, 1000);
        if (cap_q.size() > base)
            check_frame("post_abort", cap_q[base],
                        model_frame(8'h31, 0, 0, 0), 10, 16);

        // asynchronous reset mid-frame with data still waiting
        repeat (3) @(posedge clk);
        pop_one(8'h31, 16'd1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("arst_pre_line", tx, 0);
        rst = 1'b1; sp = 1'b0; present = 1'b1;
        #1 check("arst_line", tx, 1);
        @(negedge clk);
        check("arst_rd", rd, 0);
        check("arst_busy", busy, 0);
        @(posedge clk); #2;
        present = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // randomized frames against the frame model
        for (int i = 0; i < 8; i++) begin
            logic [7:0]  rd_d;
            logic [15:0] rd_b;
            bit          rp;
            bit          rm;
            bit          rs;
            rd_d = 8'($urandom);
            rd_b = 16'($urandom_range(0, 3));
            rp   = 1'($urandom);
            rm   = 1'($urandom);
            rs   = 1'($urandom);
            base = cap_q.size();
            pop_one(rd_d, rd_b, rp, rm, rs);
            wait_caps(base + 1, 1000);
            if (cap_q.size() > base)
                check_frame($sformatf("rnd%0d", i), cap_q[base],
                            model_frame(rd_d, rp, rm, rs), rp ? 11 : 10,
                            OS * ((rd_b == 16'd0) ? 1 : int'(rd_b)));
            repeat (2) @(posedge clk);
        end

        ndone = 0;
        foreach (cap_q[i]) if (!cap_q[i].aborted) ndone++;
        check("done_total", done_cycles.size(), ndone);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmit engine of the UART: pops bytes from the TX buffer and shifts them out on the serial line.
- Uses the baud divisor, parity, bit-order and start-polarity settings from the UART configuration register block.
- Sits between the TX FIFO read port and the UART TX pin, in the bus2ip_clk domain.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- OVERSAMPLE, 16, prescaler ticks per bit period.

Ports:
- bus2ip_clk  input  1  system clock (125 MHz nominal).
- bus2ip_rst  input  1  asynchronous reset, active high.
- baud_config_i  input  16  prescaler divisor: clocks per oversample tick; 0 is treated as 1.
- parity_en_i  input  1  1 = append even-parity bit.
- msb_first_i  input  1  1 = MSB shifted first; 0 = LSB first.
- start_polarity_i  input  1  0 = low start, high stop/idle; 1 = high start, low stop/idle.
- reset_buffer_i  input  1  FIFO flush pulse; also aborts any frame in progress.
- tx_buffer_data_present_i  input  1  TX FIFO non-empty.
- tx_buffer_data_i  input  DATA_BITS  FIFO head word (first-word-fall-through).
- tx_buffer_rd_o  output  1  one-cycle pop strobe.
- uart_tx_o  output  1  serial line.
- tx_busy_o  output  1  high from pop until the end of the stop bit.
- tx_done_o  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset values:
  - tx_buffer_rd_o=0, tx_busy_o=0, tx_done_o=0.
  - uart_tx_o = ~start_polarity_i (idle level); the idle line follows start_polarity_i combinationally-registered, one cycle late.
  - FSM = IDLE, counters = 0.
- Bit timing:
  - The prescaler counts 0..max(baud_config_i,1)-1 and issues a tick on wrap.
  - The bit counter advances on every OVERSAMPLE-th tick.
  - One bit period = OVERSAMPLE*max(baud_config_i,1) clocks, e.g. 16*68 = 1088 clocks ≈ 115200 baud at 125 MHz.
  - The prescaler and tick counter clear at frame start, so every bit is exactly one period.
- Configuration latching:
  - baud_config_i, parity_en_i, msb_first_i and start_polarity_i are captured in the pop cycle and held for the whole frame.
  - Changes mid-frame take effect on the next frame only.
- IDLE:
  - If tx_buffer_data_present_i=1 and reset_buffer_i=0: assert tx_buffer_rd_o for exactly one cycle, latch tx_buffer_data_i and the configuration, set tx_busy_o, and go to START.
  - Back-to-back frames: the pop occurs in the cycle after tx_done_o, so there is one idle-level cycle between the stop bit and the next start bit.
- START: uart_tx_o = latched start_polarity for one bit period, starting the cycle after the pop; then go to DATA.
- DATA:
  - DATA_BITS bit periods, shifting from bit 0 upward (LSB first) or from bit DATA_BITS-1 downward (MSB first).
  - Data bits are never inverted by start_polarity.
  - Next state is PARITY if parity is enabled, otherwise STOP.
- PARITY: one bit period driving the XOR of the data bits (even parity, unaffected by polarity); then STOP.
- STOP:
  - One bit period at the latched stop level (~start_polarity).
  - On its final cycle: pulse tx_done_o, clear tx_busy_o, go to IDLE.
- Frame length: 10 bit periods without parity, 11 with parity.
- reset_buffer_i=1 in any state:
  - Abort the frame next cycle: go to IDLE, drive uart_tx_o to idle level, clear tx_busy_o, no tx_done_o.
  - No pop while reset_buffer_i=1.
- Asynchronous reset mid-frame: line goes to idle level immediately; no pop is issued until reset is released.
- tx_buffer_rd_o is never asserted outside IDLE and never while data_present=0.

Test Plan:
- Reset, data_present=0 -> uart_tx_o=1, rd/busy/done=0; set start_polarity=1 -> uart_tx_o=0 within 2 cycles.
- baud_config=2, parity off, LSB first, push 0x31 -> one rd pulse; line shows 0,1,0,0,0,1,1,0,0,1, each held 32 clocks; done pulses 320 clocks after the start bit begins; busy high throughout.
- Same byte with msb_first=1 and parity_en=1 -> data 0,0,1,1,0,0,0,1, then parity 1, then stop 1; 352 clocks total.
- start_polarity=1, baud_config=0 -> bit = 16 clocks; start bit high, stop bit low; data bits 0x31 not inverted.
- Two bytes queued -> second rd occurs the cycle after the first done, with exactly one idle cycle between frames; changing baud_config mid-frame does not alter the current frame.
- reset_buffer pulse during DATA bit 3 -> line returns to idle next cycle, busy=0, no done pulse; a new byte then transmits cleanly.
